// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX->MEM pipeline register with stall bubble, flush and madd/msub feedback.
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [1:0]          cnt_o
);
  localparam int MW = ADDR_W + 3*DATA_W + 2;
  localparam int AW = 2*DATA_W + 2;
  logic [MW-1:0] mem_q, mem_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          bubble, hold;
  always_comb begin
    bubble = stall[3] & ~stall[4];
    hold   = stall[3] & stall[4];
    mem_d  = (flush | bubble) ? '0 : hold ? mem_q
           : {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo};
    // the madd/msub partial product survives only while EX is held back
    acc_d  = flush ? '0 : hold ? acc_q : bubble ? {hilo_i, cnt_i} : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      acc_q <= '0;
    end else begin
      mem_q <= mem_d;
      acc_q <= acc_d;
    end
  end
  assign {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo} = mem_q;
  assign {hilo_o, cnt_o} = acc_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: table-driven check of the EX->MEM register plus multi-cycle corner sequences.
module tb_ex_mem_reg;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic [5:0]  stall;
  logic [4:0]  ex_wd, mem_wd;
  logic        ex_wreg, ex_whilo, mem_wreg, mem_whilo;
  logic [31:0] ex_wdata, ex_hi, ex_lo, mem_wdata, mem_hi, mem_lo;
  logic [63:0] hilo_i, hilo_o;
  logic [1:0]  cnt_i, cnt_o;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst; logic flush; logic [5:0] st;
    logic [4:0] wd; logic wreg; logic [31:0] wdata, hi, lo; logic whilo;
    logic [63:0] hilo; logic [1:0] cnt;
    logic [4:0] e_wd; logic e_wreg; logic [31:0] e_wdata, e_hi, e_lo; logic e_whilo;
    logic [63:0] e_hilo; logic [1:0] e_cnt;
  } vec_t;
  vec_t tv[20];

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  task automatic chk(input string n, input int idx, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", n, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; flush = v.flush; stall = v.st;
    ex_wd = v.wd; ex_wreg = v.wreg; ex_wdata = v.wdata; ex_hi = v.hi; ex_lo = v.lo;
    ex_whilo = v.whilo; hilo_i = v.hilo; cnt_i = v.cnt;
  endtask

  initial begin
    tv[0]  = '{1'b1,1'b0,6'h00,5'd3,1'b1,32'hDEADBEEF,32'h0,32'h0,1'b0,64'h0,2'd0, 5'd0,1'b0,32'h0,32'h0,32'h0,1'b0,64'h0,2'd0};
    tv[1]  = '{1'b1,1'b0,6'h00,5'd3,1'b1,32'hDEADBEEF,32'h0,32'h0,1'b0,64'h0,2'd0, 5'd0,1'b0,32'h0,32'h0,32'h0,1'b0,64'h0,2'd0};
    tv[2]  = '{1'b0,1'b0,6'h00,5'd3,1'b1,32'hDEADBEEF,32'h0,32'h0,1'b0,64'h0,2'd0, 5'd3,1'b1,32'hDEADBEEF,32'h0,32'h0,1'b0,64'h0,2'd0};
    tv[3]  = '{1'b0,1'b0,6'h00,5'd3,1'b1,32'h11111111,32'h0,32'h0,1'b0,64'h0,2'd0, 5'd3,1'b1,32'h11111111,32'h0,32'h0,1'b0,64'h0,2'd0};
    tv[4]  = '{1'b0,1'b0,6'h00,5'd3,1'b1,32'h22222222,32'h0,32'h0,1'b0,64'h0,2'd0, 5'd3,1'b1,32'h22222222,32'h0,32'h0,1'b0,64'h0,2'd0};
    tv[5]  = '{1'b0,1'b0,6'h00,5'd0,1'b0,32'h0,32'hA,32'hB,1'b1,64'h0,2'd0, 5'd0,1'b0,32'h0,32'hA,32'hB,1'b1,64'h0,2'd0};
    tv[6]  = '{1'b0,1'b0,6'h0F,5'd7,1'b1,32'h33,32'h0,32'h0,1'b0,64'h0000_0001_0000_0002,2'd1, 5'd0,1'b0,32'h0,32'h0,32'h0,1'b0,64'h0000_0001_0000_0002,2'd1};
    tv[7]  = '{1'b0,1'b0,6'h00,5'd7,1'b1,32'h44,32'h0,32'h0,1'b0,64'h99,2'd2, 5'd7,1'b1,32'h44,32'h0,32'h0,1'b0,64'h0,2'd0};
    tv[8]  = '{1'b0,1'b0,6'h00,5'd4,1'b1,32'h5A5A5A5A,32'h0,32'h0,1'b0,64'h0,2'd0, 5'd4,1'b1,32'h5A5A5A5A,32'h0,32'h0,1'b0,64'h0,2'd0};
    tv[9]  = '{1'b0,1'b0,6'h1F,5'd9,1'b0,32'hFFFFFFFF,32'h1,32'h2,1'b1,64'hF0,2'd3, 5'd4,1'b1,32'h5A5A5A5A,32'h0,32'h0,1'b0,64'h0,2'd0};
    tv[10] = tv[9];
    tv[11] = tv[9];
    tv[12] = '{1'b0,1'b0,6'h0F,5'd9,1'b1,32'hFFFFFFFF,32'h0,32'h0,1'b0,64'h0000_0001_0000_0002,2'd1, 5'd0,1'b0,32'h0,32'h0,32'h0,1'b0,64'h0000_0001_0000_0002,2'd1};
    tv[13] = '{1'b0,1'b0,6'h1F,5'd9,1'b1,32'hFFFFFFFF,32'h0,32'h0,1'b0,64'h77,2'd2, 5'd0,1'b0,32'h0,32'h0,32'h0,1'b0,64'h0000_0001_0000_0002,2'd1};
    tv[14] = '{1'b0,1'b1,6'h1F,5'd9,1'b1,32'hFFFFFFFF,32'h0,32'h0,1'b0,64'h77,2'd2, 5'd0,1'b0,32'h0,32'h0,32'h0,1'b0,64'h0,2'd0};
    tv[15] = '{1'b0,1'b0,6'h00,5'd6,1'b1,32'h12345678,32'hC,32'hD,1'b1,64'h0,2'd0, 5'd6,1'b1,32'h12345678,32'hC,32'hD,1'b1,64'h0,2'd0};
    tv[16] = '{1'b1,1'b1,6'h00,5'd6,1'b1,32'h12345678,32'hC,32'hD,1'b1,64'h0,2'd0, 5'd0,1'b0,32'h0,32'h0,32'h0,1'b0,64'h0,2'd0};
    tv[17] = '{1'b0,1'b0,6'h0F,5'd6,1'b1,32'h12345678,32'hC,32'hD,1'b1,64'h3,2'd1, 5'd0,1'b0,32'h0,32'h0,32'h0,1'b0,64'h3,2'd1};
    tv[18] = '{1'b1,1'b0,6'h0F,5'd6,1'b1,32'h12345678,32'hC,32'hD,1'b1,64'h3,2'd1, 5'd0,1'b0,32'h0,32'h0,32'h0,1'b0,64'h0,2'd0};
    tv[19] = '{1'b0,1'b0,6'h00,5'd31,1'b1,32'h89ABCDEF,32'hFFFFFFFF,32'h0,1'b1,64'h3,2'd1, 5'd31,1'b1,32'h89ABCDEF,32'hFFFFFFFF,32'h0,1'b1,64'h0,2'd0};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tv[i]);
      @(posedge clk);
      #1;
      chk("mem_wd", i, 64'(mem_wd), 64'(tv[i].e_wd));
      chk("mem_wreg", i, 64'(mem_wreg), 64'(tv[i].e_wreg));
      chk("mem_wdata", i, 64'(mem_wdata), 64'(tv[i].e_wdata));
      chk("mem_hi", i, 64'(mem_hi), 64'(tv[i].e_hi));
      chk("mem_lo", i, 64'(mem_lo), 64'(tv[i].e_lo));
      chk("mem_whilo", i, 64'(mem_whilo), 64'(tv[i].e_whilo));
      chk("hilo_o", i, hilo_o, tv[i].e_hilo);
      chk("cnt_o", i, 64'(cnt_o), 64'(tv[i].e_cnt));
    end
    // consecutive bubbles track the EX counter each cycle
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      stall = 6'h0F; cnt_i = 2'(k); hilo_i = 64'(k) << 32;
      @(posedge clk);
      #1;
      chk("bubble_cnt", 100 + k, 64'(cnt_o), 64'(k));
      chk("bubble_hilo", 100 + k, hilo_o, 64'(k) << 32);
      chk("bubble_wreg", 100 + k, 64'(mem_wreg), 64'h0);
    end
    // inputs changing between edges must not reach the outputs
    @(negedge clk);
    stall = 6'h00; ex_wdata = 32'hCAFEF00D; ex_wd = 5'd12;
    @(posedge clk);
    #1;
    ex_wdata = 32'h0BADBEEF; ex_wd = 5'd1; stall = 6'h0F; cnt_i = 2'd3; flush = 1'b1;
    #2;
    chk("no_comb_wdata", 200, 64'(mem_wdata), 64'hCAFEF00D);
    chk("no_comb_wd", 200, 64'(mem_wd), 64'd12);
    chk("no_comb_cnt", 200, 64'(cnt_o), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute (EX) stage and the memory-access (MEM) stage of the 5-stage MIPS32 core.
- On each clock it captures the EX result (destination register, write enable, write data, HI/LO update) and presents it to MEM.
- Supports pipeline stall with bubble insertion and exception flush.
- Carries the two-cycle multiply-accumulate (madd/msub) intermediate product and cycle counter back to EX while EX is stalled.

Parameters:
- DATA_W, 32, general-purpose register / HI / LO data width (`RegBus`).
- ADDR_W, 5, register-file address width (`RegAddrBus`).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset (`RstEnable` = 1'b1); sampled on rising clk.
- stall  input  6  pipeline stall vector from ctrl: [0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb.
- flush  input  1  exception flush from ctrl; clears the stage.
- ex_wd  input  ADDR_W  EX destination register address.
- ex_wreg  input  1  EX register write enable.
- ex_wdata  input  DATA_W  EX result data.
- ex_hi  input  DATA_W  EX HI value.
- ex_lo  input  DATA_W  EX LO value.
- ex_whilo  input  1  EX HI/LO write enable.
- hilo_i  input  2*DATA_W  EX madd/msub intermediate product, first cycle.
- cnt_i  input  2  EX multi-cycle counter.
- mem_wd  output  ADDR_W  registered destination address to MEM.
- mem_wreg  output  1  registered write enable to MEM.
- mem_wdata  output  DATA_W  registered result to MEM.
- mem_hi  output  DATA_W  registered HI to MEM.
- mem_lo  output  DATA_W  registered LO to MEM.
- mem_whilo  output  1  registered HI/LO write enable to MEM.
- hilo_o  output  2*DATA_W  intermediate product fed back to EX.
- cnt_o  output  2  counter fed back to EX.

Behaviour:
- All outputs are registers, updated only on rising clk. Latency EX→MEM is exactly 1 cycle.
- Update priority per edge (highest first): rst, flush, bubble, advance, hold.
- rst=1:
  - mem_wd=`NOPRegAddr` (0), mem_wreg=`WriteDisable` (0), mem_wdata/mem_hi/mem_lo=`ZeroWord`, mem_whilo=0.
  - hilo_o=0, cnt_o=0.
- flush=1 (rst=0): same values as reset on all outputs. Flush overrides any stall.
- Bubble, stall[3]=1 and stall[4]=0 (EX stalled, MEM running):
  - All mem_* outputs take their reset values (NOP into MEM).
  - hilo_o<=hilo_i and cnt_o<=cnt_i, preserving madd/msub progress across the stall.
- Advance, stall[3]=0:
  - mem_* <= corresponding ex_* inputs.
  - hilo_o<=0, cnt_o<=0.
  - stall[4] is ignored in this case; ctrl never asserts stall[4] without stall[3].
- Hold, stall[3]=1 and stall[4]=1: every output keeps its previous value, including hilo_o and cnt_o.
- No arithmetic is performed; widths pass through unchanged.
- Reset or flush arriving mid madd/msub clears cnt_o/hilo_o. EX restarts the instruction from cnt=0.
- No combinational path from any input to any output.

Test Plan:
- Reset:
  - Drive ex_wd=5'd3, ex_wreg=1, ex_wdata=32'hDEADBEEF with rst=1 for 2 cycles.
  - Required: all mem_* = 0, hilo_o=0, cnt_o=0.
  - After rst=0, the next edge gives mem_wd=3, mem_wreg=1, mem_wdata=32'hDEADBEEF.
- Pass-through:
  - Stall=6'b0. Cycle N: ex_wdata=32'h11111111. Cycle N+1: ex_wdata=32'h22222222.
  - Required: mem_wdata shows 32'h11111111 after edge N and 32'h22222222 after edge N+1.
  - Also ex_whilo=1, ex_hi=32'hA, ex_lo=32'hB → mem_whilo=1, mem_hi=32'hA, mem_lo=32'hB one cycle later.
- Bubble with madd:
  - Stall=6'b001111, cnt_i=2'b01, hilo_i=64'h0000_0001_0000_0002, ex_wreg=1.
  - Required: mem_wreg=0, mem_wd=0, cnt_o=2'b01, hilo_o=64'h0000_0001_0000_0002.
  - Then stall=0 with cnt_i=2'b10: required cnt_o=0, hilo_o=0, mem_* = ex_*.
- Hold:
  - Load mem_wdata=32'h5A5A5A5A, then stall=6'b011111 for 3 cycles while ex_wdata=32'hFFFFFFFF.
  - Required: mem_wdata stays 32'h5A5A5A5A and cnt_o/hilo_o stay unchanged.
- Flush priority:
  - Stall=6'b011111 and flush=1 in the same cycle.
  - Required: all outputs 0 next edge.
  - rst=1 together with flush=1 also gives all outputs 0.
- Reset mid-accumulate:
  - cnt_o=2'b01 held via bubble, then rst=1 for one edge.
  - Required: cnt_o=0, hilo_o=0.
